// File: rtl/sample_decimator_if.sv
// sample_decimator_if: control, channel data and output handshake of the sample decimator
interface sample_decimator_if #(
    parameter int DIV_WIDTH  = 24,
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic                  wr_divider;
    logic [DIV_WIDTH-1:0]  divider_in;
    logic [3:0]            channel_en;
    logic [DATA_WIDTH-1:0] indata;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] outdata;
    logic                  valid_out;
    logic                  overrun;

    modport master (
        output enable, wr_divider, divider_in, channel_en, indata, ready_in,
        input  outdata, valid_out, overrun
    );

    modport slave (
        input  enable, wr_divider, divider_in, channel_en, indata, ready_in,
        output outdata, valid_out, overrun
    );
endinterface

// File: rtl/sample_decimator.sv
// sample_decimator: divides the channel-word stream down to one masked sample every div+1 enabled edges
module sample_decimator #(
    parameter int DIV_WIDTH  = 24,
    parameter int DATA_WIDTH = 32
) (
    input logic              clock,
    input logic              reset_n,
    sample_decimator_if.slave bus
);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

    logic [DIV_WIDTH-1:0]  div;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] captured;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  due;

    assign due = bus.enable && !bus.wr_divider && cnt == '0;

    // zero every byte whose group is masked off
    always_comb begin
        captured = '0;
        for (int g = 0; g < 4; g++)
            if (bus.channel_en[g]) captured[8*g +: 8] = bus.indata[8*g +: 8];
    end

    // divider load, reload while disabled, count down to the due edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            cnt <= '0;
        end else if (bus.wr_divider) begin
            div <= bus.divider_in;
            cnt <= bus.divider_in;
        end else begin
            cnt <= (!bus.enable || cnt == '0) ? div : cnt - DIV_ONE;
        end
    end

    // output holding register: load on a due edge when free or being drained, else drop and flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (due && (!valid_q || bus.ready_in)) begin
                out_q   <= captured;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_in) begin
                valid_q <= 1'b0;
            end
            overrun_q <= !bus.enable ? 1'b0 : (due && valid_q && !bus.ready_in) ? 1'b1 : overrun_q;
        end
    end

    assign bus.outdata   = out_q;
    assign bus.valid_out = valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sample_decimator.sv
// tb_sample_decimator: directed vector table, randomized run against a behavioural model, async reset check
module tb_sample_decimator;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    sample_decimator_if #(.DIV_WIDTH(24), .DATA_WIDTH(32)) bus ();

    sample_decimator #(.DIV_WIDTH(24), .DATA_WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [23:0] din;
        logic        en;
        logic [3:0]  ch;
        logic [31:0] data;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    vec_t vec [19];

    longint      m_div;
    longint      m_n;
    logic        m_v;
    logic [31:0] m_d;
    logic        m_o;

    function automatic logic [31:0] masked(logic [31:0] w, logic [3:0] ch);
        logic [31:0] r;
        r = '0;
        for (int g = 0; g < 4; g++)
            if (ch[g]) r[8*g +: 8] = w[8*g +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_div = 0;
        m_n   = 0;
        m_v   = 1'b0;
        m_d   = '0;
        m_o   = 1'b0;
    endtask

    // behavioural model: count enabled edges since the last load/disable; every (div+1)th one is due
    task automatic model_step();
        logic due;
        due = 1'b0;
        if (bus.wr_divider) begin
            m_div = longint'(bus.divider_in);
            m_n   = 0;
        end else if (!bus.enable) begin
            m_n = 0;
        end else begin
            m_n = m_n + 1;
            due = (m_n % (m_div + 1)) == 0;
        end
        if (due && (!m_v || bus.ready_in)) begin
            m_v = 1'b1;
            m_d = masked(bus.indata, bus.channel_en);
        end else if (due) begin
            m_o = 1'b1;
        end else if (m_v && bus.ready_in) begin
            m_v = 1'b0;
        end
        if (!bus.enable) m_o = 1'b0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic wr, logic [23:0] din, logic en, logic [3:0] ch, logic [31:0] data, logic rdy);
        bus.wr_divider = wr;
        bus.divider_in = din;
        bus.enable     = en;
        bus.channel_en = ch;
        bus.indata     = data;
        bus.ready_in   = rdy;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic check_model(string tag);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, {31'd0, m_v});
        if (m_v) check({tag, "_data"}, bus.outdata, m_d);
        check({tag, "_overrun"}, {31'd0, bus.overrun}, {31'd0, m_o});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vec[0]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h1,        1'b1, 1'b1, 32'h1,        1'b0};
        vec[1]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h2,        1'b1, 1'b1, 32'h2,        1'b0};
        vec[2]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h3,        1'b1, 1'b1, 32'h3,        1'b0};
        vec[3]  = '{1'b0, 24'd0, 1'b1, 4'h5, 32'hAABBCCDD, 1'b1, 1'b1, 32'h00BB00DD, 1'b0};
        vec[4]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h11,       1'b1, 1'b1, 32'h11,       1'b0};
        vec[5]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h22,       1'b0, 1'b1, 32'h11,       1'b1};
        vec[6]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h33,       1'b0, 1'b1, 32'h11,       1'b1};
        vec[7]  = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h44,       1'b0, 1'b1, 32'h11,       1'b1};
        vec[8]  = '{1'b0, 24'd0, 1'b0, 4'hF, 32'h55,       1'b0, 1'b1, 32'h11,       1'b0};
        vec[9]  = '{1'b0, 24'd0, 1'b0, 4'hF, 32'h55,       1'b1, 1'b0, 32'h11,       1'b0};
        vec[10] = '{1'b1, 24'd3, 1'b1, 4'hF, 32'h66,       1'b1, 1'b0, 32'h11,       1'b0};
        vec[11] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h1,        1'b1, 1'b0, 32'h11,       1'b0};
        vec[12] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h2,        1'b1, 1'b0, 32'h11,       1'b0};
        vec[13] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h3,        1'b1, 1'b0, 32'h11,       1'b0};
        vec[14] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h4,        1'b1, 1'b1, 32'h4,        1'b0};
        vec[15] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h5,        1'b1, 1'b0, 32'h4,        1'b0};
        vec[16] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h6,        1'b1, 1'b0, 32'h4,        1'b0};
        vec[17] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h7,        1'b1, 1'b0, 32'h4,        1'b0};
        vec[18] = '{1'b0, 24'd0, 1'b1, 4'hF, 32'h8,        1'b1, 1'b1, 32'h8,        1'b0};

        reset_n = 1'b0;
        drive(1'b0, 24'd0, 1'b0, 4'hF, 32'h0, 1'b0);
        model_reset();
        #12;
        check("reset_valid", {31'd0, bus.valid_out}, 32'd0);
        check("reset_data", bus.outdata, 32'd0);
        check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
        #5 reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vec[i].wr, vec[i].din, vec[i].en, vec[i].ch, vec[i].data, vec[i].rdy);
            cyc();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.valid_out}, {31'd0, vec[i].ev});
            check($sformatf("vec%0d_data", i), bus.outdata, vec[i].ed);
            check($sformatf("vec%0d_overrun", i), {31'd0, bus.overrun}, {31'd0, vec[i].eo});
        end

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, 24'($urandom_range(0, 6)), $urandom_range(0, 9) != 0,
                  4'($urandom), $urandom, $urandom_range(0, 9) < 7);
            cyc();
            check_model($sformatf("rnd%0d", i));
        end

        drive(1'b1, 24'd0, 1'b1, 4'hF, 32'h0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 24'd0, 1'b1, 4'hF, 32'hC0DE0000 + 32'(i), 1'b0);
            cyc();
        end
        check("pre_reset_valid", {31'd0, bus.valid_out}, 32'd1);
        check("pre_reset_overrun", {31'd0, bus.overrun}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_valid", {31'd0, bus.valid_out}, 32'd0);
        check("async_reset_data", bus.outdata, 32'd0);
        check("async_reset_overrun", {31'd0, bus.overrun}, 32'd0);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 24'd0, 1'b1, 4'hF, 32'h100 + 32'(i), 1'b1);
            cyc();
            check_model($sformatf("resume%0d", i));
        end
        check("resume_last_data", bus.outdata, 32'h105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
